// File: rtl/uart_pkg.sv
// Shared UART definitions: register map, STATUS bit positions, receiver
// FSM encoding and the clocks-per-bit calculation.
package uart_pkg;

    // Register byte offsets; bits [3:2] of the bus address select the register.
    localparam logic [3:0] REG_DATA   = 4'h0;
    localparam logic [3:0] REG_STATUS = 4'h4;

    // STATUS register bit positions.
    localparam int STAT_VALID     = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_FRAME_ERR = 2;
    localparam int STAT_OVERRUN   = 3;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_HIGH = 3'd4
    } rx_state_e;

    // Clocks per bit, truncated.
    function automatic int unsigned calc_cpb(input int unsigned clk_mhz,
                                             input int unsigned baud);
        return (clk_mhz * 32'd1000000) / baud;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO. A push into a full FIFO is accepted only when a pop happens
// in the same cycle; a pop of an empty FIFO is ignored. Pointers wrap
// naturally because the depth is a power of two.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        do_push  = push && (!full || pop);
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver (8N1, LSB first) with a small receive FIFO and a two-register
// bus interface (DATA, STATUS).
//
//  state        | meaning
//  -------------+---------------------------------------------------------
//  RX_IDLE      | line idle, waiting for a low level on rxs
//  RX_START     | half-bit wait, then confirm the start bit (else glitch)
//  RX_DATA      | eight full-bit waits, sampling one data bit each
//  RX_STOP      | full-bit wait, then sample the stop bit
//  RX_WAIT_HIGH | framing error seen, waiting for the line to return high
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_MHZ    = 12,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    input  logic [3:0]  addr_in,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);
    localparam int unsigned CPB   = calc_cpb(CLK_MHZ, BAUD);
    localparam int unsigned HALF  = CPB / 2;
    localparam int          CNT_W = (CPB > 2) ? $clog2(CPB) : 1;
    localparam logic [CNT_W-1:0] CPB_LD  = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(HALF - 1);

    logic             meta_q, meta_d;
    logic             rxs_q, rxs_d;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;

    logic             cnt_tc;
    logic             push;
    logic             fe_set;
    logic             overrun_set;
    logic [1:0]       reg_idx;
    logic             rd_data_acc;
    logic             wr_status;
    logic             pop;
    logic [7:0]       fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [31:0]      status;

    logic             unused_ok;
    assign unused_ok = ^{wdata[31:4], wdata[1:0], addr_in[1:0]};

    // Two-flop synchronizer on the asynchronous serial line.
    always_comb begin
        meta_d = rx;
        rxs_d  = meta_q;
    end

    // Receiver FSM: bit timing via a down-counter with terminal-count compare.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        push    = 1'b0;
        fe_set  = 1'b0;
        cnt_tc  = (cnt_q == '0);
        case (state_q)
            RX_IDLE: begin
                if (!rxs_q) begin
                    state_d = RX_START;
                    cnt_d   = HALF_LD;
                    bit_d   = '0;
                end
            end
            RX_START: begin
                if (cnt_tc) begin
                    if (!rxs_q) begin
                        state_d = RX_DATA;
                        cnt_d   = CPB_LD;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt_tc) begin
                    shift_d = {rxs_q, shift_q[7:1]};
                    cnt_d   = CPB_LD;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (cnt_tc) begin
                    if (rxs_q) begin
                        push    = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        fe_set  = 1'b1;
                        state_d = RX_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RX_WAIT_HIGH: begin
                if (rxs_q) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // Bus decode, sticky flags (a set beats a clear) and read mux.
    always_comb begin
        reg_idx     = addr_in[3:2];
        rd_data_acc = req && !we && (reg_idx == REG_DATA[3:2]);
        wr_status   = req && we && (reg_idx == REG_STATUS[3:2]);
        pop         = rd_data_acc && !fifo_empty;
        overrun_set = push && fifo_full && !pop;
        frame_err_d = fe_set | (frame_err_q & ~(wr_status & wdata[STAT_FRAME_ERR]));
        overrun_d   = overrun_set | (overrun_q & ~(wr_status & wdata[STAT_OVERRUN]));

        status                 = 32'h0;
        status[STAT_VALID]     = !fifo_empty;
        status[STAT_FULL]      = fifo_full;
        status[STAT_FRAME_ERR] = frame_err_q;
        status[STAT_OVERRUN]   = overrun_q;

        if (reg_idx == REG_DATA[3:2]) begin
            rdata = fifo_empty ? 32'h0 : {24'h0, fifo_head};
        end else if (reg_idx == REG_STATUS[3:2]) begin
            rdata = status;
        end else begin
            rdata = 32'h0;
        end
    end

    assign irq = !fifo_empty;

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q      <= 1'b1;
            rxs_q       <= 1'b1;
            state_q     <= RX_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            meta_q      <= meta_d;
            rxs_q       <= rxs_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (shift_q),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: the expected FIFO contents and sticky flags
// are kept as a byte queue plus two bits, updated from frame-level events.
module tb_uart_rx;
    localparam int CPB   = (12 * 1000000) / 115200;
    localparam int HALF  = CPB / 2;
    localparam int DEPTH = 4;
    // Stop-sample edge, counted in clocks from the start-bit falling edge:
    // two synchronizer flops, one cycle to leave IDLE, HALF, then 9 bits.
    localparam int E_OFS = 3 + HALF + 9 * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx = 1'b1;
    logic [3:0]  addr_in = 4'h0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        irq;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  mq[$];
    logic        m_ovr = 1'b0;
    logic        m_fe = 1'b0;
    logic        auto_read = 1'b0;

    uart_rx #(.CLK_MHZ(12), .BAUD(115200), .FIFO_DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .rx      (rx),
        .addr_in (addr_in),
        .req     (req),
        .we      (we),
        .wdata   (wdata),
        .rdata   (rdata),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #950000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] m_status();
        return {28'h0, m_ovr, m_fe, (mq.size() == DEPTH), (mq.size() != 0)};
    endfunction

    function automatic void m_frame_ok(input logic [7:0] b);
        if (mq.size() < DEPTH) mq.push_back(b);
        else m_ovr = 1'b1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        addr_in = a; we = 1'b0; req = 1'b1;
        #1 d = rdata;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        addr_in = a; we = 1'b1; wdata = d; req = 1'b1;
        @(negedge clk);
        req = 1'b0; we = 1'b0;
    endtask

    task automatic read_data(input string name);
        logic [31:0] d, exp;
        bus_read(4'h0, d);
        if (mq.size() != 0) exp = {24'h0, mq.pop_front()};
        else exp = 32'h0;
        check(name, d, exp);
    endtask

    task automatic read_status(input string name);
        logic [31:0] d;
        bus_read(4'h4, d);
        check(name, d, m_status());
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic read_on_push(input string name);
        logic [31:0] d, exp;
        idle(E_OFS - 1);
        bus_read(4'h0, d);
        exp = {24'h0, mq.pop_front()};
        check(name, d, exp);
    endtask

    task automatic clear_on_push();
        idle(E_OFS - 1);
        bus_write(4'h4, 32'h8);
    endtask

    task automatic fill_fifo(input logic [7:0] base);
        for (int i = 0; i < DEPTH; i++) begin
            m_frame_ok(base + 8'(i));
            send_frame(base + 8'(i), 1'b1);
            idle(3);
        end
    endtask

    // Monitor: pops a byte whenever the DUT signals data while auto_read is on.
    initial begin
        logic [31:0] d;
        forever begin
            @(negedge clk);
            if (auto_read && irq) begin
                bus_read(4'h0, d);
                if (mq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL mon_extra_byte actual=0x%0h required=no_data", d);
                end else begin
                    check("mon_data", d, {24'h0, mq.pop_front()});
                end
            end
        end
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  b;
        int          got;
        int          r;

        idle(3);
        rst = 1'b0;
        idle(2);
        check("rst_irq", irq, 32'h0);
        read_status("rst_status");
        read_data("rst_data");

        // Single frame.
        m_frame_ok(8'hA5);
        send_frame(8'hA5, 1'b1);
        idle(5);
        read_status("a5_status");
        check("a5_irq", irq, 32'h1);
        read_data("a5_data");
        read_status("a5_status_after");
        check("a5_irq_after", irq, 32'h0);

        // Short low pulse is rejected; receiver then takes a normal frame.
        rx = 1'b0;
        idle(30);
        rx = 1'b1;
        idle(100);
        read_status("glitch_status");
        m_frame_ok(8'h5A);
        send_frame(8'h5A, 1'b1);
        idle(5);
        read_data("post_glitch_data");

        // Framing error and its clear.
        m_fe = 1'b1;
        send_frame(8'h3C, 1'b0);
        idle(10);
        read_status("fe_status");
        check("fe_irq", irq, 32'h0);
        bus_write(4'h4, 32'h4);
        m_fe = 1'b0;
        read_status("fe_cleared");

        // Overflow with five frames, unused offsets, in-order draining.
        for (int i = 1; i <= 5; i++) begin
            m_frame_ok(8'(i));
            send_frame(8'(i), 1'b1);
            idle(3);
        end
        read_status("ovf_status");
        bus_write(4'h0, 32'hFF);
        bus_write(4'h8, 32'hF);
        bus_write(4'hC, 32'hF);
        bus_write(4'h4, 32'h3);
        bus_read(4'h8, d);
        check("rd_0x8", d, 32'h0);
        bus_read(4'hC, d);
        check("rd_0xC", d, 32'h0);
        read_status("ovf_status_kept");
        for (int i = 0; i < DEPTH; i++) read_data("ovf_data");
        read_data("empty_data");
        bus_write(4'h4, 32'h8);
        m_ovr = 1'b0;
        read_status("ovf_cleared");

        // Byte-to-visibility latency measured through the stop bit.
        b = 8'hC3;
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(CPB);
        end
        check("lat_pre_stop_irq", irq, 32'h0);
        rx = 1'b1;
        got = -1;
        for (int k = 1; k <= CPB; k++) begin
            @(negedge clk);
            if (irq && got < 0) got = k;
        end
        check("lat_cycles", got, HALF + 3);
        m_frame_ok(b);
        read_data("lat_data");

        // Reset in the middle of a frame.
        b = 8'h55;
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 3; i++) begin
            rx = b[i];
            idle(CPB);
        end
        rst = 1'b1;
        rx = 1'b1;
        idle(2);
        rst = 1'b0;
        mq.delete();
        m_ovr = 1'b0;
        m_fe = 1'b0;
        idle(2);
        read_status("midrst_status");
        m_frame_ok(8'h66);
        send_frame(8'h66, 1'b1);
        idle(5);
        read_data("midrst_data");
        read_status("midrst_status_after");

        // Full FIFO, DATA read on the push cycle: no overrun.
        fill_fifo(8'h10);
        read_status("full_status");
        fork
            send_frame(8'h20, 1'b1);
            read_on_push("simul_pop_data");
        join
        m_frame_ok(8'h20);
        idle(5);
        read_status("simul_status");
        for (int i = 0; i < DEPTH; i++) read_data("simul_drain");

        // Full FIFO, overrun clear on the push cycle: the set wins.
        fill_fifo(8'h30);
        fork
            send_frame(8'h40, 1'b1);
            clear_on_push();
        join
        m_ovr = 1'b0;
        m_frame_ok(8'h40);
        idle(5);
        read_status("setwins_status");
        bus_write(4'h4, 32'h8);
        m_ovr = 1'b0;
        read_status("setwins_cleared");
        for (int i = 0; i < DEPTH; i++) read_data("setwins_drain");

        // Randomized traffic with the monitor draining the FIFO.
        auto_read = 1'b1;
        for (int n = 0; n < 10; n++) begin
            r = int'($urandom_range(0, 5));
            b = 8'($urandom);
            if (r == 0) begin
                rx = 1'b0;
                idle(int'($urandom_range(5, 40)));
                rx = 1'b1;
                idle(80);
            end else if (r == 1) begin
                m_fe = 1'b1;
                send_frame(b, 1'b0);
            end else begin
                m_frame_ok(b);
                send_frame(b, 1'b1);
            end
            idle(5 + int'($urandom_range(0, 30)));
        end
        for (int k = 0; k < 20 * CPB && mq.size() != 0; k++) @(negedge clk);
        check("rand_drain", mq.size(), 32'h0);
        idle(5);
        auto_read = 1'b0;
        idle(2);
        read_status("rand_status");
        bus_write(4'h4, 32'hC);
        m_fe = 1'b0;
        m_ovr = 1'b0;
        read_status("rand_cleared");
        check("final_irq", irq, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
